id_ex_pipe: RTL
===============

Name: id_ex_pipe

Overview:
- Pipeline register between decode (ID) and execute (EX) of the 4-stage core (IF, ID, EX, WB).
- Captures the decode control outputs (alu_sel, alusrc, regwrite), the register operands, the immediate and the destination address.
- Resolves operand B (register or immediate), converts opcode 2'b11 (NOP) into a clean bubble and handles stall/flush.
- Optionally bypasses WB write-back data into the captured operands.

Parameters:
DATA_W, 8, operand/immediate width
REG_AW, 3, register address width
CNT_W, 8, bubble counter width

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
id_valid  in  1  ID holds a real instruction
id_opcode  in  2  decoded opcode (00 ADD, 01 ADDI, 11 NOP, 10 reserved)
id_alu_sel  in  1  control unit ALU select
id_alusrc  in  1  control unit operand-B source (1 = immediate)
id_regwrite  in  1  control unit write enable
id_rs1_addr  in  REG_AW  source 1 address
id_rs2_addr  in  REG_AW  source 2 address
id_rs1_data  in  DATA_W  register file read 1
id_rs2_data  in  DATA_W  register file read 2
id_imm  in  DATA_W  sign-extended immediate
id_rd_addr  in  REG_AW  destination address
stall  in  1  hold register contents
flush  in  1  replace next contents with bubble
wb_regwrite  in  1  WB stage writes this cycle
wb_rd_addr  in  REG_AW  WB destination
wb_data  in  DATA_W  WB write data
ex_valid  out  1  EX holds a real instruction
ex_alu_sel  out  1  registered ALU select
ex_regwrite  out  1  registered write enable
ex_op_a  out  DATA_W  operand A
ex_op_b  out  DATA_W  operand B (register or immediate, already muxed)
ex_rd_addr  out  REG_AW  destination
bubble_cnt  out  CNT_W  saturating count of bubbles inserted

Behaviour:
- Reset (async assert, sync release): ex_valid, ex_alu_sel, ex_regwrite = 0; ex_op_a, ex_op_b, ex_rd_addr = 0; bubble_cnt = 0.
- Latency: one clock. ID values present before edge N appear on outputs after edge N.
- Priority per edge: flush > stall > capture.
- flush=1: load a bubble regardless of stall. A bubble is ex_valid=0, ex_regwrite=0, ex_alu_sel=0, data and rd = 0.
- stall=1, flush=0: all outputs hold, and bubble_cnt holds.
- Capture (stall=0, flush=0):
  - Bubble conditions: id_valid=0, id_opcode=2'b11, or id_opcode=2'b10. Each loads a bubble.
  - The X-valued alu_sel/alusrc from the control unit for NOP must never reach the outputs.
  - Otherwise load: ex_valid=1; ex_alu_sel=id_alu_sel; ex_regwrite=id_regwrite; ex_rd_addr=id_rd_addr.
  - ex_op_a = resolved rs1.
  - ex_op_b = id_alusrc ? id_imm : resolved rs2.
- bubble_cnt increments by 1 on each edge that loads a bubble (flush or capture path). It saturates at all-ones with no wrap.
- Resolved rsN = id_rsN_data unless the bypass feature is enabled.
- Reset asserted mid-stall or mid-flush: reset wins immediately, asynchronously.

Optional Feature:
ID_EX_BYPASS_EN
- Defined:
  - Resolved rsN = wb_data when wb_regwrite=1, wb_rd_addr==id_rsN_addr and wb_rd_addr!=0. Otherwise id_rsN_data.
  - Covers the same-cycle write/read hazard of the register file.
  - Address 0 is never bypassed.
  - The bypass applies to rs2 even when alusrc=1, but the result is then discarded by the operand-B mux.
- Undefined: no wb_* comparison logic. The wb_* ports remain present but are unused.

Decomposition:
- Shared package proc_pkg:
  - Opcode constants OP_ADD=2'b00, OP_ADDI=2'b01, OP_RSVD=2'b10, OP_NOP=2'b11.
  - Default widths DATA_W/REG_AW.
  - Bubble-field reset values.
- One natural sub-module: id_ex_bypass, the combinational rsN resolver, instantiated twice (rs1, rs2). It contains the ID_EX_BYPASS_EN conditional.

Test Plan:
- Reset: drive rst_n=0 mid-cycle with random inputs -> all outputs 0 immediately; hold values through the first edge after release only if id_valid=0.
- ADDI capture: opcode 01, alusrc=1, imm=8'h05, rs1_data=8'h10, rd=3 -> next edge: ex_valid=1, op_a=8'h10, op_b=8'h05, rd=3, regwrite=1, alu_sel=1.
- NOP with X controls: opcode 11, alu_sel/alusrc=X -> ex_valid=0, ex_alu_sel=0, ex_regwrite=0 (no X on outputs), bubble_cnt 0->1.
- Stall/flush priority:
  - Load ADD, then stall=1 for 3 cycles with changing ID inputs -> outputs frozen.
  - Then stall=1 and flush=1 together -> bubble loaded, bubble_cnt+1.
- Bypass (macro defined):
  - wb_regwrite=1, wb_rd=2, wb_data=8'hAA, id_rs1_addr=2, rs1_data=8'h00 -> ex_op_a=8'hAA.
  - Same stimulus with wb_rd=0 -> ex_op_a=8'h00.
  - With the macro undefined -> 8'h00 in both cases.
- Saturation: 260 consecutive bubbles with CNT_W=8 -> bubble_cnt reaches 8'hFF and stays there.

Source files
------------

// File: rtl/proc_pkg.sv
// Shared definitions for the 4-stage core (IF, ID, EX, WB): opcode encodings,
// default datapath widths and the field values that make up a pipeline bubble.
package proc_pkg;

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_ADDI = 2'b01;
  localparam logic [1:0] OP_RSVD = 2'b10;
  localparam logic [1:0] OP_NOP  = 2'b11;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_REG_AW = 3;

  localparam logic BUBBLE_VLD      = 1'b0;
  localparam logic BUBBLE_ALU_SEL  = 1'b0;
  localparam logic BUBBLE_REGWRITE = 1'b0;

  // NOP and the reserved encoding both travel down the pipe as bubbles.
  function automatic logic is_bubble_op(input logic [1:0] opcode);
    return (opcode == OP_NOP) || (opcode == OP_RSVD);
  endfunction

endpackage

// File: rtl/id_ex_bypass.sv
// Combinational source-operand resolver for one register read port.
// With ID_EX_BYPASS_EN defined, a same-cycle WB write to the addressed
// register (never x0) is forwarded in place of the stale register-file data.
// Without it the register-file data passes straight through.
module id_ex_bypass
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW
) (
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic [DATA_W-1:0] rs_res
);

`ifdef ID_EX_BYPASS_EN
  logic hit;

  assign hit    = wb_regwrite && (wb_rd_addr == rs_addr) && (wb_rd_addr != '0);
  assign rs_res = hit ? wb_data : rs_data;
`else
  logic unused_wb;

  assign unused_wb = ^{wb_regwrite, wb_rd_addr, wb_data, rs_addr};
  assign rs_res    = rs_data;
`endif

endmodule

// File: rtl/id_ex_pipe.sv
// ID -> EX pipeline register. Captures decode control and operands, muxes
// operand B (register or immediate), turns NOP/reserved/invalid slots into
// clean bubbles and counts them with a saturating counter.
// Priority per edge: flush > stall > capture.
// Optional: ID_EX_BYPASS_EN forwards WB write data into the captured operands.
module id_ex_pipe
  import proc_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int REG_AW = DEF_REG_AW,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [1:0]        id_opcode,
  input  logic              id_alu_sel,
  input  logic              id_alusrc,
  input  logic              id_regwrite,
  input  logic [REG_AW-1:0] id_rs1_addr,
  input  logic [REG_AW-1:0] id_rs2_addr,
  input  logic [DATA_W-1:0] id_rs1_data,
  input  logic [DATA_W-1:0] id_rs2_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_AW-1:0] id_rd_addr,
  input  logic              stall,
  input  logic              flush,
  input  logic              wb_regwrite,
  input  logic [REG_AW-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              ex_valid,
  output logic              ex_alu_sel,
  output logic              ex_regwrite,
  output logic [DATA_W-1:0] ex_op_a,
  output logic [DATA_W-1:0] ex_op_b,
  output logic [REG_AW-1:0] ex_rd_addr,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic [DATA_W-1:0]        rs1_res;
  logic [DATA_W-1:0]        rs2_res;
  logic signed [DATA_W-1:0] op_b_p0;
  logic                     bubble_p0;

  logic                     vld_p1;
  logic                     alu_sel_p1;
  logic                     regwrite_p1;
  logic signed [DATA_W-1:0] op_a_p1;
  logic signed [DATA_W-1:0] op_b_p1;
  logic [REG_AW-1:0]        rd_p1;
  logic [CNT_W-1:0]         bubble_cnt_p1;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  id_ex_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_rs1 (
    .rs_addr     (id_rs1_addr),
    .rs_data     (id_rs1_data),
    .wb_regwrite (wb_regwrite),
    .wb_rd_addr  (wb_rd_addr),
    .wb_data     (wb_data),
    .rs_res      (rs1_res)
  );

  id_ex_bypass #(.DATA_W(DATA_W), .REG_AW(REG_AW)) u_bypass_rs2 (
    .rs_addr     (id_rs2_addr),
    .rs_data     (id_rs2_data),
    .wb_regwrite (wb_regwrite),
    .wb_rd_addr  (wb_rd_addr),
    .wb_data     (wb_data),
    .rs_res      (rs2_res)
  );

  // Stage p0 (ID side): bubble detection and operand-B source select.
  always_comb begin
    bubble_p0 = !id_valid || is_bubble_op(id_opcode);
    op_b_p0   = id_alusrc ? id_imm : rs2_res;
  end

  // Stage p1 (EX side): flush loads a bubble, stall holds, otherwise capture.
  // Bubble loads never look at alu_sel/alusrc, so undefined NOP controls stay out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1        <= BUBBLE_VLD;
      alu_sel_p1    <= BUBBLE_ALU_SEL;
      regwrite_p1   <= BUBBLE_REGWRITE;
      op_a_p1       <= '0;
      op_b_p1       <= '0;
      rd_p1         <= '0;
      bubble_cnt_p1 <= '0;
    end else if (flush || (!stall && bubble_p0)) begin
      vld_p1        <= BUBBLE_VLD;
      alu_sel_p1    <= BUBBLE_ALU_SEL;
      regwrite_p1   <= BUBBLE_REGWRITE;
      op_a_p1       <= '0;
      op_b_p1       <= '0;
      rd_p1         <= '0;
      bubble_cnt_p1 <= sat_inc(bubble_cnt_p1);
    end else if (!stall) begin
      vld_p1        <= 1'b1;
      alu_sel_p1    <= id_alu_sel;
      regwrite_p1   <= id_regwrite;
      op_a_p1       <= rs1_res;
      op_b_p1       <= op_b_p0;
      rd_p1         <= id_rd_addr;
    end
  end

  assign ex_valid    = vld_p1;
  assign ex_alu_sel  = alu_sel_p1;
  assign ex_regwrite = regwrite_p1;
  assign ex_op_a     = op_a_p1;
  assign ex_op_b     = op_b_p1;
  assign ex_rd_addr  = rd_p1;
  assign bubble_cnt  = bubble_cnt_p1;

endmodule
